// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the dual-writeback register file.
package wb_regfile_pkg;
    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned FLAG_W     = 4;
    localparam int unsigned CNT_W      = 16;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;
endpackage

// File: rtl/wb_read_port.sv
// One combinational read port with write-through bypass; port 2 (younger) wins.
module wb_read_port
    import wb_regfile_pkg::*;
#(
    parameter int unsigned NR = NUM_REGS,
    parameter int unsigned AW = REG_ADDR_W,
    parameter int unsigned DW = DATA_W
) (
    input  logic [DW-1:0] regs_i [NR],
    input  logic          we1_i,
    input  logic [AW-1:0] waddr1_i,
    input  logic [DW-1:0] wdata1_i,
    input  logic          we2_i,
    input  logic [AW-1:0] waddr2_i,
    input  logic [DW-1:0] wdata2_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    always_comb begin
        rdata_o = regs_i[raddr_i];
        if (we1_i && (waddr1_i == raddr_i)) rdata_o = wdata1_i;
        if (we2_i && (waddr2_i == raddr_i)) rdata_o = wdata2_i;
    end
endmodule

// File: rtl/wb_regfile.sv
// Dual-writeback register file with flag register, bypassed reads and
// writeback activity counter.
module wb_regfile #(
    parameter int unsigned NUM_REGS   = wb_regfile_pkg::NUM_REGS,
    parameter int unsigned REG_ADDR_W = wb_regfile_pkg::REG_ADDR_W,
    parameter int unsigned DATA_W     = wb_regfile_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regWrite1,
    input  logic [REG_ADDR_W-1:0] DestReg1,
    input  logic [DATA_W-1:0]     WriteData1,
    input  logic                  regWrite2,
    input  logic [REG_ADDR_W-1:0] DestReg2,
    input  logic [DATA_W-1:0]     WriteData2,
    input  logic                  flagWrite1,
    input  logic [3:0]            inst1Flags,
    input  logic                  flagWrite2,
    input  logic [3:0]            inst2Flags,
    input  logic [REG_ADDR_W-1:0] ReadReg1,
    input  logic [REG_ADDR_W-1:0] ReadReg2,
    input  logic [REG_ADDR_W-1:0] ReadReg3,
    input  logic [REG_ADDR_W-1:0] ReadReg4,
    output logic [DATA_W-1:0]     ReadData1,
    output logic [DATA_W-1:0]     ReadData2,
    output logic [DATA_W-1:0]     ReadData3,
    output logic [DATA_W-1:0]     ReadData4,
    output logic [3:0]            NZCV,
    output logic                  wbConflict,
    output logic [15:0]           wbCount
);
    localparam int unsigned CNT_W  = wb_regfile_pkg::CNT_W;
    localparam int unsigned NPORTS = 4;

    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic [3:0]            flags_q, flags_d;
    logic                  conflict_q, conflict_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [REG_ADDR_W-1:0] rd_addr [NPORTS];
    logic [DATA_W-1:0]     rd_data [NPORTS];

    // Next state: port 2 applied last so it overrides a same-destination port 1 write
    always_comb begin
        regs_d = regs_q;
        if (regWrite1) regs_d[DestReg1] = WriteData1;
        if (regWrite2) regs_d[DestReg2] = WriteData2;

        flags_d = flags_q;
        if (flagWrite2)      flags_d = inst2Flags;
        else if (flagWrite1) flags_d = inst1Flags;

        conflict_d = regWrite1 && regWrite2 && (DestReg1 == DestReg2);

        count_d = count_q;
        if (regWrite1 || regWrite2) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            flags_q    <= '0;
            conflict_q <= 1'b0;
            count_q    <= '0;
        end else begin
            regs_q     <= regs_d;
            flags_q    <= flags_d;
            conflict_q <= conflict_d;
            count_q    <= count_d;
        end
    end

    // NZCV previews the post-edge flag value
    assign NZCV       = flags_d;
    assign wbConflict = conflict_q;
    assign wbCount    = count_q;

    assign rd_addr[0] = ReadReg1;
    assign rd_addr[1] = ReadReg2;
    assign rd_addr[2] = ReadReg3;
    assign rd_addr[3] = ReadReg4;

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        wb_read_port #(
            .NR (NUM_REGS),
            .AW (REG_ADDR_W),
            .DW (DATA_W)
        ) u_rd (
            .regs_i   (regs_q),
            .we1_i    (regWrite1),
            .waddr1_i (DestReg1),
            .wdata1_i (WriteData1),
            .we2_i    (regWrite2),
            .waddr2_i (DestReg2),
            .wdata2_i (WriteData2),
            .raddr_i  (rd_addr[p]),
            .rdata_o  (rd_data[p])
        );
    end

    assign ReadData1 = rd_data[0];
    assign ReadData2 = rd_data[1];
    assign ReadData3 = rd_data[2];
    assign ReadData4 = rd_data[3];
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile; expectations are queued with their sample
// cycle and checked by an independent negedge monitor.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        reset;
    logic        regWrite1, regWrite2, flagWrite1, flagWrite2;
    logic [2:0]  DestReg1, DestReg2;
    logic [31:0] WriteData1, WriteData2;
    logic [3:0]  inst1Flags, inst2Flags, NZCV;
    logic [2:0]  ReadReg1, ReadReg2, ReadReg3, ReadReg4;
    logic [31:0] ReadData1, ReadData2, ReadData3, ReadData4;
    logic        wbConflict;
    logic [15:0] wbCount;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    wb_regfile dut (
        .clk(clk), .reset(reset),
        .regWrite1(regWrite1), .DestReg1(DestReg1), .WriteData1(WriteData1),
        .regWrite2(regWrite2), .DestReg2(DestReg2), .WriteData2(WriteData2),
        .flagWrite1(flagWrite1), .inst1Flags(inst1Flags),
        .flagWrite2(flagWrite2), .inst2Flags(inst2Flags),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadReg3(ReadReg3), .ReadReg4(ReadReg4),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .ReadData3(ReadData3), .ReadData4(ReadData4),
        .NZCV(NZCV), .wbConflict(wbConflict), .wbCount(wbCount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return ReadData1;
            1:       return ReadData2;
            2:       return ReadData3;
            3:       return ReadData4;
            4:       return 32'(NZCV);
            5:       return 32'(wbConflict);
            default: return 32'(wbCount);
        endcase
    endfunction

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if (a !== e.exp) begin
                errors++;
                $display("FAIL %s: got %h want %h", e.name, a, e.exp);
            end
        end
    end

    task automatic expect_v(input int sel, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.exp = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regWrite1 = 1'b0; regWrite2 = 1'b0; flagWrite1 = 1'b0; flagWrite2 = 1'b0;
        DestReg1 = 3'd0; DestReg2 = 3'd0; WriteData1 = '0; WriteData2 = '0;
        inst1Flags = 4'h0; inst2Flags = 4'h0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle();
        ReadReg1 = 3'd0; ReadReg2 = 3'd0; ReadReg3 = 3'd0; ReadReg4 = 3'd0;
        step();
        expect_v(0, 32'h0, "reset_rd1");
        expect_v(4, 32'h0, "reset_nzcv");
        expect_v(5, 32'h0, "reset_conflict");
        expect_v(6, 32'h0, "reset_count");
        step();
        reset = 1'b0;

        // Single write, bypass then stored
        regWrite1 = 1'b1; DestReg1 = 3'd3; WriteData1 = 32'hDEADBEEF; ReadReg1 = 3'd3;
        expect_v(0, 32'hDEADBEEF, "r3_bypass");
        step();
        idle();
        expect_v(0, 32'hDEADBEEF, "r3_stored");
        expect_v(6, 32'd1, "count_1");
        step();

        // Same-destination double write: port 2 wins
        regWrite1 = 1'b1; DestReg1 = 3'd5; WriteData1 = 32'h11;
        regWrite2 = 1'b1; DestReg2 = 3'd5; WriteData2 = 32'h22; ReadReg2 = 3'd5;
        expect_v(1, 32'h22, "r5_bypass");
        expect_v(5, 32'h0, "conflict_pre");
        step();
        idle();
        expect_v(1, 32'h22, "r5_stored");
        expect_v(5, 32'h1, "conflict_pulse");
        expect_v(6, 32'd2, "count_2");
        step();
        expect_v(5, 32'h0, "conflict_clear");

        // Distinct-destination double write, including r0
        regWrite1 = 1'b1; DestReg1 = 3'd0; WriteData1 = 32'h100;
        regWrite2 = 1'b1; DestReg2 = 3'd7; WriteData2 = 32'h700;
        ReadReg3 = 3'd0; ReadReg4 = 3'd7;
        expect_v(2, 32'h100, "r0_bypass");
        expect_v(3, 32'h700, "r7_bypass");
        step();
        idle();
        expect_v(2, 32'h100, "r0_stored");
        expect_v(3, 32'h700, "r7_stored");
        expect_v(5, 32'h0, "no_conflict");
        expect_v(6, 32'd3, "count_3");
        step();

        // Disabled write ports must be invisible
        DestReg1 = 3'd2; WriteData1 = 32'hBAD; DestReg2 = 3'd2; WriteData2 = 32'hBAD2; ReadReg1 = 3'd2;
        expect_v(0, 32'h0, "disabled_bypass");
        step();
        idle();
        expect_v(0, 32'h0, "disabled_stored");
        expect_v(6, 32'd3, "disabled_count");
        step();

        // Flags: inst2 priority, then hold, then inst1 alone
        flagWrite1 = 1'b1; inst1Flags = 4'b1000; flagWrite2 = 1'b1; inst2Flags = 4'b0100;
        expect_v(4, 32'h4, "nzcv_bypass");
        step();
        idle();
        expect_v(4, 32'h4, "nzcv_stored");
        step();
        inst1Flags = 4'hF; inst2Flags = 4'hF;
        expect_v(4, 32'h4, "nzcv_hold");
        step();
        flagWrite1 = 1'b1; inst1Flags = 4'b0001; inst2Flags = 4'hF;
        expect_v(4, 32'h1, "nzcv_inst1");
        step();
        idle();
        expect_v(4, 32'h1, "nzcv_inst1_stored");
        step();

        // Drive the counter to 0xFFFF, then wrap
        for (int i = 0; i < 65532; i++) begin
            regWrite1 = 1'b1; DestReg1 = 3'd6; WriteData1 = 32'(i);
            step();
        end
        idle();
        ReadReg1 = 3'd6;
        expect_v(6, 32'hFFFF, "count_ffff");
        expect_v(0, 32'd65531, "r6_last");
        step();
        regWrite2 = 1'b1; DestReg2 = 3'd1; WriteData2 = 32'h1234;
        step();
        idle();
        expect_v(6, 32'h0, "count_wrap");
        step();
        regWrite1 = 1'b1; DestReg1 = 3'd4; WriteData1 = 32'h44;
        step();
        idle();
        expect_v(6, 32'd1, "count_after_wrap");
        step();

        // Mid-cycle reset with writes pending
        regWrite1 = 1'b1; DestReg1 = 3'd2; WriteData1 = 32'hCAFE;
        regWrite2 = 1'b1; DestReg2 = 3'd2; WriteData2 = 32'hF00D;
        flagWrite1 = 1'b1; inst1Flags = 4'hA;
        ReadReg1 = 3'd3; ReadReg2 = 3'd2; ReadReg3 = 3'd4;
        #1;
        reset = 1'b1;
        expect_v(0, 32'h0, "rst_r3");
        expect_v(1, 32'hF00D, "rst_bypass");
        expect_v(2, 32'h0, "rst_r4");
        expect_v(4, 32'hA, "rst_nzcv_bypass");
        expect_v(5, 32'h0, "rst_conflict");
        expect_v(6, 32'h0, "rst_count");
        step();
        flagWrite1 = 1'b0;
        expect_v(4, 32'h0, "rst_flags");
        expect_v(0, 32'h0, "rst_held_r3");
        expect_v(6, 32'h0, "rst_held_count");
        step();
        reset = 1'b0;
        expect_v(6, 32'h0, "post_rst_count");
        step();
        idle();
        expect_v(1, 32'hF00D, "first_write");
        expect_v(2, 32'h0, "r4_cleared");
        expect_v(5, 32'h1, "first_conflict");
        expect_v(6, 32'd1, "first_count");
        step();
        step();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning the number of architectural registers.
REQ-002 SHALL have parameter REG_ADDR_W, default 3, meaning the register-address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning the register data width.
REQ-004 SHALL have the following ports:
- clk  input  1  sole clock; rising edge.
- reset  input  1  asynchronous, active-high reset.
- regWrite1  input  1  write enable, inst1 (ALU result).
- DestReg1  input  REG_ADDR_W  destination, inst1.
- WriteData1  input  DATA_W  write data, inst1.
- regWrite2  input  1  write enable, inst2 (memory result).
- DestReg2  input  REG_ADDR_W  destination, inst2.
- WriteData2  input  DATA_W  write data, inst2.
- flagWrite1  input  1  flag update enable, inst1.
- inst1Flags  input  4  {N,Z,C,V}, inst1.
- flagWrite2  input  1  flag update enable, inst2.
- inst2Flags  input  4  {N,Z,C,V}, inst2.
- ReadReg1..ReadReg4  input  REG_ADDR_W each  read addresses: two sources per issued instruction.
- ReadData1..ReadData4  output  DATA_W each  read data.
- NZCV  output  4  architectural flags, bypassed.
- wbConflict  output  1  registered one-cycle pulse: same-destination double write.
- wbCount  output  16  count of cycles with at least one register write.

Function
REQ-005 SHALL write WriteData1 to DestReg1 on a rising clk edge when regWrite1=1, and WriteData2 to DestReg2 when regWrite2=1; both writes SHALL take effect on the same edge.
REQ-006 SHALL store only WriteData2 when both enables are 1 and DestReg1==DestReg2, because inst2 is younger in program order.
REQ-007 SHALL drive wbConflict=1 for exactly the cycle after an edge on which REQ-006 applied, and 0 otherwise.
REQ-008 SHALL make ReadDataN combinational from ReadRegN with write-through bypass:
- If regWrite2 and DestReg2==ReadRegN, return WriteData2.
- Else if regWrite1 and DestReg1==ReadRegN, return WriteData1.
- Else return the stored value.
REQ-009 SHALL update the flag register on a rising edge from inst2Flags when flagWrite2=1, else from inst1Flags when flagWrite1=1, else hold.
REQ-010 SHALL bypass flags onto NZCV with the same priority as REQ-009, so NZCV shows the value the flag register will hold after the next edge.
REQ-011 SHALL increment wbCount by 1, modulo 2^16 (0xFFFF wraps to 0x0000), on each edge where regWrite1 or regWrite2 is 1; a same-destination double write counts once.
REQ-012 SHALL treat every register, including register 0, as general purpose and writable.
REQ-013 SHALL ignore DestRegN/WriteDataN values whenever the matching enable is 0; such values SHALL never appear on read ports.

Reset
REQ-014 SHALL, while reset=1, asynchronously clear all registers, flags, wbConflict and wbCount to 0, regardless of clk or any enable.
REQ-015 SHALL keep bypass paths active during reset, so ReadDataN and NZCV follow REQ-008 and REQ-010 over zeroed storage.
REQ-016 SHALL perform the first write on the first rising edge after reset deasserts.

Structure
REQ-017 SHALL place NUM_REGS, REG_ADDR_W, DATA_W and the flag bit indices (N=3, Z=2, C=1, V=0) in the shared pipeline package.
REQ-018 SHALL implement the bypass read as sub-module wb_read_port, instantiated four times.

Verification
REQ-019 Write 0xDEADBEEF to r3 via port1, then read r3 on the next cycle -> ReadData=0xDEADBEEF.
REQ-020 Same cycle: port1 writes 0x11 and port2 writes 0x22, both to r5 -> ReadData(r5)=0x22 same cycle, stored r5=0x22, wbConflict=1 for one cycle only, wbCount +1.
REQ-021 flagWrite1=1 with 4'b1000 and flagWrite2=1 with 4'b0100 -> NZCV=4'b0100 combinationally and after the edge; with both enables 0 next cycle -> NZCV holds 4'b0100.
REQ-022 Preload wbCount=0xFFFF, then apply one write cycle -> wbCount=0x0000.
REQ-023 Assert reset mid-cycle between edges while writes are pending -> all stored registers, flags, wbCount and wbConflict read 0 immediately; the write lands on the first edge after deassert.
